// File: rtl/debug_pkg.sv
// Shared opcodes, state encoding and pulse-width limits for the host-side step sequencer.
package debug_pkg;

   localparam logic [1:0] OP_STOP      = 2'b00;
   localparam logic [1:0] OP_STEP_N    = 2'b01;
   localparam logic [1:0] OP_RUN_BREAK = 2'b10;
   localparam logic [1:0] OP_FREE      = 2'b11;

   typedef enum logic [1:0] {
      ST_FREE    = 2'b00,
      ST_IDLE    = 2'b01,
      ST_STEP_HI = 2'b10,
      ST_STEP_LO = 2'b11
   } state_t;

   // The debugger's 2-flop synchroniser needs at least this much high/low time per edge.
   localparam int PULSE_HI_MIN = 2;
   localparam int PULSE_LO_MIN = 3;
   localparam int PULSE_MAX    = 15;

endpackage

// File: rtl/debug_step_pulse.sv
// Phase timer for the step pulse: counts cycles inside STEP_HI / STEP_LO and
// strobes on the last cycle of each phase.
module debug_step_pulse #(
   parameter int PULSE_HI = 4,
   parameter int PULSE_LO = 4
) (
   input  logic phy_clk,
   input  logic reset_n,
   input  logic in_hi,
   input  logic in_lo,
   output logic hi_done,
   output logic lo_done
);

   logic [3:0] timer_r;

   assign hi_done = in_hi && (timer_r == 4'(PULSE_HI - 1));
   assign lo_done = in_lo && (timer_r == 4'(PULSE_LO - 1));

   // Phase cycle counter, restarted at every phase boundary and held at zero outside a pulse.
   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_r <= 4'd0;
      end else if (!(in_hi || in_lo) || hi_done || lo_done) begin
         timer_r <= 4'd0;
      end else begin
         timer_r <= timer_r + 4'd1;
      end
   end

endmodule

// File: rtl/debug_step_ctrl.sv
// Host command decoder and step sequencer driving debug_enable / single_step
// into the single-step debugger, with count, timeout and breakpoint stops.
module debug_step_ctrl
   import debug_pkg::*;
#(
   parameter int PULSE_HI = 4,
   parameter int PULSE_LO = 4,
   parameter int CNT_W    = 16
) (
   input  logic             phy_clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             break_en,
   input  logic [7:0]       break_value,
   input  logic [7:0]       clock_counter,
   output logic             debug_enable,
   output logic             single_step,
   output logic             busy,
   output logic [CNT_W-1:0] steps_done,
   output logic             halted_at_break,
   output logic             cmd_err
);

   generate
      if (PULSE_HI < PULSE_HI_MIN || PULSE_HI > PULSE_MAX ||
          PULSE_LO < PULSE_LO_MIN || PULSE_LO > PULSE_MAX) begin : g_bad_pulse
         $error("debug_step_ctrl: PULSE_HI/PULSE_LO outside legal range");
      end
   endgenerate

   state_t           state_r, state_s;
   logic [1:0]       op_r;
   logic [CNT_W-1:0] count_r;
   logic             brk_en_r;
   logic [7:0]       brk_val_r;
   logic             stop_pend_r;
   logic [CNT_W-1:0] steps_done_r;
   logic             halted_r, cmd_err_r;
   logic             debug_enable_r, single_step_r, busy_r;

   logic in_run_s, stop_cmd_s, accept_s, reject_s, latch_s, clr_steps_s, halt_set_s;
   logic hi_done_s, lo_done_s;

   debug_step_pulse #(.PULSE_HI(PULSE_HI), .PULSE_LO(PULSE_LO)) u_pulse (
      .phy_clk (phy_clk),
      .reset_n (reset_n),
      .in_hi   (state_r == ST_STEP_HI),
      .in_lo   (state_r == ST_STEP_LO),
      .hi_done (hi_done_s),
      .lo_done (lo_done_s)
   );

   // Command acceptance and next-state decode; a pulse, once started, always runs HI then full LO.
   always_comb begin
      state_s     = state_r;
      accept_s    = 1'b0;
      reject_s    = 1'b0;
      halt_set_s  = 1'b0;
      in_run_s    = (state_r == ST_STEP_HI) || (state_r == ST_STEP_LO);
      stop_cmd_s  = cmd_valid && (cmd_op == OP_STOP);
      if (cmd_valid) begin
         if (stop_cmd_s || !in_run_s) begin
            accept_s = 1'b1;
         end else begin
            reject_s = 1'b1;
         end
      end else begin
         accept_s = 1'b0;
      end
      latch_s     = accept_s && !in_run_s;
      clr_steps_s = latch_s && ((cmd_op == OP_STEP_N) || (cmd_op == OP_RUN_BREAK));

      case (state_r)
         ST_FREE, ST_IDLE: begin
            if (accept_s) begin
               case (cmd_op)
                  OP_STOP:      state_s = ST_IDLE;
                  OP_STEP_N: begin
                     if (cmd_count != {CNT_W{1'b0}}) begin
                        state_s = ST_STEP_HI;
                     end else begin
                        state_s = state_r;
                     end
                  end
                  OP_RUN_BREAK: state_s = ST_STEP_HI;
                  OP_FREE:      state_s = ST_FREE;
                  default:      state_s = state_r;
               endcase
            end else begin
               state_s = state_r;
            end
         end
         ST_STEP_HI: begin
            if (hi_done_s) begin
               state_s = ST_STEP_LO;
            end else begin
               state_s = ST_STEP_HI;
            end
         end
         ST_STEP_LO: begin
            if (!lo_done_s) begin
               state_s = ST_STEP_LO;
            end else if (brk_en_r && (clock_counter == brk_val_r)) begin
               state_s    = ST_IDLE;
               halt_set_s = 1'b1;
            end else if ((op_r == OP_STEP_N) && (steps_done_r == count_r)) begin
               state_s = ST_IDLE;
            end else if ((op_r == OP_RUN_BREAK) && (count_r != {CNT_W{1'b0}}) &&
                         (steps_done_r == count_r)) begin
               state_s = ST_IDLE;
            end else if (stop_pend_r || stop_cmd_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_STEP_HI;
            end
         end
         default: state_s = ST_FREE;
      endcase
   end

   // State, latched run parameters, step counter, sticky flags and registered outputs.
   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_FREE;
         op_r           <= OP_STOP;
         count_r        <= {CNT_W{1'b0}};
         brk_en_r       <= 1'b0;
         brk_val_r      <= 8'd0;
         stop_pend_r    <= 1'b0;
         steps_done_r   <= {CNT_W{1'b0}};
         halted_r       <= 1'b0;
         cmd_err_r      <= 1'b0;
         debug_enable_r <= 1'b0;
         single_step_r  <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         state_r        <= state_s;
         debug_enable_r <= (state_s != ST_FREE);
         single_step_r  <= (state_s == ST_STEP_HI);
         busy_r         <= (state_s == ST_STEP_HI) || (state_s == ST_STEP_LO);

         if (latch_s) begin
            op_r      <= cmd_op;
            count_r   <= cmd_count;
            brk_en_r  <= break_en;
            brk_val_r <= break_value;
         end

         if (clr_steps_s) begin
            steps_done_r <= {CNT_W{1'b0}};
         end else if (hi_done_s && (steps_done_r != {CNT_W{1'b1}})) begin
            steps_done_r <= steps_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end

         // A STOP seen mid-pulse waits for the end of LO; leaving the run discards it.
         if ((state_s == ST_IDLE) || (state_s == ST_FREE)) begin
            stop_pend_r <= 1'b0;
         end else if (stop_cmd_s) begin
            stop_pend_r <= 1'b1;
         end

         if (halt_set_s) begin
            halted_r <= 1'b1;
         end else if (accept_s) begin
            halted_r <= 1'b0;
         end

         if (reject_s) begin
            cmd_err_r <= 1'b1;
         end else if (accept_s) begin
            cmd_err_r <= 1'b0;
         end
      end
   end

   assign debug_enable    = debug_enable_r;
   assign single_step     = single_step_r;
   assign busy            = busy_r;
   assign steps_done      = steps_done_r;
   assign halted_at_break = halted_r;
   assign cmd_err         = cmd_err_r;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed bench for debug_step_ctrl: a vector table of complete commands plus
// hand-written sequences for STOP, rejection, coincidence and reset corners.
module tb_debug_step_ctrl;
   import debug_pkg::*;

   localparam int PULSE_HI = 4;
   localparam int PULSE_LO = 4;

   logic        phy_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'b00;
   logic [15:0] cmd_count = 16'd0;
   logic        break_en = 1'b0;
   logic [7:0]  break_value = 8'd0;
   logic [7:0]  dbg_ctr = 8'd0;
   logic        debug_enable, single_step, busy, halted_at_break, cmd_err;
   logic [15:0] steps_done;

   int n_vec = 0;
   int n_err = 0;

   debug_step_ctrl #(.PULSE_HI(PULSE_HI), .PULSE_LO(PULSE_LO), .CNT_W(16)) dut (
      .phy_clk(phy_clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_count(cmd_count), .break_en(break_en), .break_value(break_value),
      .clock_counter(dbg_ctr), .debug_enable(debug_enable), .single_step(single_step),
      .busy(busy), .steps_done(steps_done), .halted_at_break(halted_at_break), .cmd_err(cmd_err)
   );

   always #5 phy_clk = ~phy_clk;

   // Debugger model: 2-flop synchroniser and rising-edge detector advancing the cycle counter.
   logic sync1 = 1'b0, sync2 = 1'b0, sync3 = 1'b0;
   always @(posedge phy_clk) begin
      sync1 <= single_step;
      sync2 <= sync1;
      sync3 <= sync2;
      if (sync2 && !sync3) dbg_ctr <= dbg_ctr + 8'd1;
   end

   // Pulse monitor: counts pulses and flags any high or in-run low phase of the wrong width.
   int   pulses = 0, bad_hi = 0, bad_lo = 0, hi_len = 0, lo_len = 0;
   logic prev_ss = 1'b0, prev_busy = 1'b0;
   always @(negedge phy_clk) begin
      if (single_step) begin
         hi_len <= prev_ss ? hi_len + 1 : 1;
         if (!prev_ss) begin
            pulses <= pulses + 1;
            if (prev_busy && lo_len != PULSE_LO) bad_lo <= bad_lo + 1;
         end
      end else begin
         lo_len <= prev_ss ? 1 : lo_len + 1;
         if (prev_ss && hi_len != PULSE_HI) bad_hi <= bad_hi + 1;
      end
      prev_ss   <= single_step;
      prev_busy <= busy;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge phy_clk);
         #1;
      end
   endtask

   // Strobe one command; returns 1 time unit after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [15:0] cnt,
                       input logic be, input logic [7:0] bv);
      @(negedge phy_clk);
      cmd_op = op; cmd_count = cnt; break_en = be; break_value = bv; cmd_valid = 1'b1;
      @(posedge phy_clk);
      #1;
      cmd_valid = 1'b0;
      cmd_count = 16'hFFFF; break_value = 8'hAA; break_en = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge phy_clk);
      while (busy && n < 2000) begin
         @(negedge phy_clk);
         n++;
      end
      #1;
      check({name, "_timeout"}, {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [15:0] cnt;
      logic        be;
      logic [7:0]  bv;
      int          npulse;
      logic [15:0] steps;
      logic        halt;
      logic [7:0]  ctr;
   } vec_t;

   vec_t vecs[9];
   int   p0, bh0, bl0;

   initial begin
      vecs[0] = '{OP_RUN_BREAK, 16'd0, 1'b1, 8'h05, 5, 16'd5, 1'b1, 8'd5};
      vecs[1] = '{OP_STEP_N,    16'd3, 1'b0, 8'h00, 3, 16'd3, 1'b0, 8'd8};
      vecs[2] = '{OP_STEP_N,    16'd1, 1'b0, 8'h00, 1, 16'd1, 1'b0, 8'd9};
      vecs[3] = '{OP_RUN_BREAK, 16'd2, 1'b0, 8'h00, 2, 16'd2, 1'b0, 8'd11};
      vecs[4] = '{OP_RUN_BREAK, 16'd0, 1'b1, 8'h0E, 3, 16'd3, 1'b1, 8'd14};
      vecs[5] = '{OP_STEP_N,    16'd5, 1'b1, 8'h10, 2, 16'd2, 1'b1, 8'd16};
      vecs[6] = '{OP_STEP_N,    16'd3, 1'b1, 8'h13, 3, 16'd3, 1'b1, 8'd19};
      vecs[7] = '{OP_STEP_N,    16'd0, 1'b0, 8'h00, 0, 16'd0, 1'b0, 8'd19};
      vecs[8] = '{OP_RUN_BREAK, 16'd2, 1'b1, 8'h00, 2, 16'd2, 1'b0, 8'd21};

      // Reset values, then an idle FREE state with no commands.
      #3;
      check("rst_debug_enable", {31'd0, debug_enable}, 32'd0);
      check("rst_single_step", {31'd0, single_step}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_steps_done", {16'd0, steps_done}, 32'd0);
      check("rst_halted", {31'd0, halted_at_break}, 32'd0);
      check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
      #20 reset_n = 1'b1;
      tick(30);
      check("free_debug_enable", {31'd0, debug_enable}, 32'd0);
      check("free_busy", {31'd0, busy}, 32'd0);
      check("free_no_pulses", pulses, 32'd0);

      send(OP_STOP, 16'd0, 1'b0, 8'h00);
      check("stop_free_debug_enable", {31'd0, debug_enable}, 32'd1);
      check("stop_free_single_step", {31'd0, single_step}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         p0 = pulses; bh0 = bad_hi; bl0 = bad_lo;
         send(vecs[i].op, vecs[i].cnt, vecs[i].be, vecs[i].bv);
         if (vecs[i].npulse > 0) check($sformatf("v%0d_latency", i), {31'd0, single_step}, 32'd1);
         wait_idle($sformatf("v%0d", i));
         check($sformatf("v%0d_pulses", i), pulses - p0, vecs[i].npulse);
         check($sformatf("v%0d_steps_done", i), {16'd0, steps_done}, {16'd0, vecs[i].steps});
         check($sformatf("v%0d_halted", i), {31'd0, halted_at_break}, {31'd0, vecs[i].halt});
         check($sformatf("v%0d_cmd_err", i), {31'd0, cmd_err}, 32'd0);
         check($sformatf("v%0d_debug_enable", i), {31'd0, debug_enable}, 32'd1);
         check($sformatf("v%0d_shape", i), (bad_hi - bh0) + (bad_lo - bl0), 32'd0);
         check($sformatf("v%0d_clock_counter", i), {24'd0, dbg_ctr}, {24'd0, vecs[i].ctr});
      end

      // STOP in the second cycle of pulse 4 of a 10-step run.
      p0 = pulses; bh0 = bad_hi; bl0 = bad_lo;
      send(OP_STEP_N, 16'd10, 1'b0, 8'h00);
      tick(25);
      send(OP_STOP, 16'd0, 1'b0, 8'h00);
      wait_idle("stop_mid");
      check("stop_mid_pulses", pulses - p0, 32'd4);
      check("stop_mid_steps_done", {16'd0, steps_done}, 32'd4);
      check("stop_mid_shape", (bad_hi - bh0) + (bad_lo - bl0), 32'd0);
      check("stop_mid_cmd_err", {31'd0, cmd_err}, 32'd0);
      check("stop_mid_debug_enable", {31'd0, debug_enable}, 32'd1);

      // A step command while busy is dropped and flagged; a count-0 step clears the flag.
      p0 = pulses;
      send(OP_STEP_N, 16'd3, 1'b0, 8'h00);
      tick(2);
      send(OP_STEP_N, 16'd5, 1'b0, 8'h00);
      check("busy_reject_cmd_err", {31'd0, cmd_err}, 32'd1);
      wait_idle("busy_reject");
      check("busy_reject_pulses", pulses - p0, 32'd3);
      check("busy_reject_steps_done", {16'd0, steps_done}, 32'd3);
      check("busy_reject_err_sticky", {31'd0, cmd_err}, 32'd1);
      p0 = pulses;
      send(OP_STEP_N, 16'd0, 1'b0, 8'h00);
      tick(10);
      check("zero_step_cmd_err", {31'd0, cmd_err}, 32'd0);
      check("zero_step_pulses", pulses - p0, 32'd0);
      check("zero_step_busy", {31'd0, busy}, 32'd0);

      // STOP landing on the last LO cycle of a run: clean completion, no stale pending stop.
      p0 = pulses;
      send(OP_STEP_N, 16'd1, 1'b0, 8'h00);
      tick(7);
      send(OP_STOP, 16'd0, 1'b0, 8'h00);
      check("stop_at_end_busy", {31'd0, busy}, 32'd0);
      check("stop_at_end_cmd_err", {31'd0, cmd_err}, 32'd0);
      check("stop_at_end_pulses", pulses - p0, 32'd1);
      p0 = pulses;
      send(OP_STEP_N, 16'd2, 1'b0, 8'h00);
      wait_idle("after_stop");
      check("after_stop_pulses", pulses - p0, 32'd2);

      send(OP_FREE, 16'd0, 1'b0, 8'h00);
      check("free_run_debug_enable", {31'd0, debug_enable}, 32'd0);
      send(OP_STOP, 16'd0, 1'b0, 8'h00);
      check("restop_debug_enable", {31'd0, debug_enable}, 32'd1);

      // Asynchronous reset in the middle of STEP_HI.
      send(OP_STEP_N, 16'd5, 1'b0, 8'h00);
      tick(1);
      check("pre_reset_single_step", {31'd0, single_step}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_single_step", {31'd0, single_step}, 32'd0);
      check("async_rst_debug_enable", {31'd0, debug_enable}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_steps_done", {16'd0, steps_done}, 32'd0);
      #3 reset_n = 1'b1;
      tick(3);
      check("post_rst_free", {31'd0, debug_enable}, 32'd0);
      send(OP_STOP, 16'd0, 1'b0, 8'h00);
      check("post_rst_stop", {31'd0, debug_enable}, 32'd1);
      send(OP_FREE, 16'd0, 1'b0, 8'h00);
      check("post_rst_free_run", {31'd0, debug_enable}, 32'd0);
      check("post_rst_single_step", {31'd0, single_step}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
